mac_layer_stage: RTL

Consumes the sequential 16-bit weight stream produced by the layer weight shift-RAM and computes one fully connected layer: N_OUT dot products of length N_IN against an input-vector buffer. Each neuron result is scaled, saturated, optionally rectified, and emitted over a valid/ready handshake to the activation buffer. The block drives the shift-RAM `en` directly, so it owns pacing of the weight stream.

---
 rtl/nn_pkg.sv | 27 ++
 rtl/mac_unit.sv | 51 +++++
 rtl/mac_layer_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the fully connected MAC layer.
// Holds layer geometry, Q8.8 saturation bounds, index widths and FSM states.
package nn_pkg;

    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int N_IN  = 784;
    localparam int N_OUT = 200;
    localparam int ACC_W = 42;

    // Fixed address/index widths seen on the ports
    localparam int PX_AW = 10;
    localparam int IDX_W = 8;

    // Q8.8 saturation bounds
    localparam int Q_MAX = (1 << (DW - 1)) - 1;
    localparam int Q_MIN = -(1 << (DW - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_e;

endpackage

// File: rtl/mac_unit.sv
// Two-stage signed multiply-accumulate with clear and in-flight tracking.
// Ports: clk, rst (async low), clr_i, valid_i (term issued this cycle),
//        a_i/b_i (operands, valid one cycle after valid_i), empty_o, acc_o.
module mac_unit #(
    parameter int DW    = nn_pkg::DW,
    parameter int ACC_W = nn_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [DW-1:0]    a_i,
    input  logic [DW-1:0]    b_i,
    output logic             empty_o,
    output logic [ACC_W-1:0] acc_o
);

    // v1: operands present on a_i/b_i this cycle
    // v2: product register holds a term still to be added
    logic                  v1_q;
    logic                  v2_q;
    logic [2*DW-1:0]       prod_q;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      prod_ext;

    assign prod_ext = {{(ACC_W - 2*DW){prod_q[2*DW-1]}}, prod_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            v1_q <= valid_i;
            v2_q <= v1_q;
            if (v1_q) begin
                prod_q <= $signed(a_i) * $signed(b_i);
            end
            if (clr_i) begin
                acc_q <= '0;
            end else if (v2_q) begin
                acc_q <= acc_q + prod_ext;
            end
        end
    end

    assign empty_o = !v1_q && !v2_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/mac_layer_stage.sv
// Fully connected layer: N_OUT dot products of length N_IN over a weight stream.
// Ports: clk, rst (async low), start, busy, done, w_en/w_data (shift-RAM),
//        px_addr/px_data (input buffer), out_valid/out_ready/out_data/out_idx.
module mac_layer_stage #(
    parameter int N_IN  = nn_pkg::N_IN,
    parameter int N_OUT = nn_pkg::N_OUT,
    parameter int DW    = nn_pkg::DW,
    parameter int FRAC  = nn_pkg::FRAC,
    parameter int ACC_W = nn_pkg::ACC_W,
    parameter int RELU  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      w_en,
    input  logic [DW-1:0]             w_data,
    output logic [nn_pkg::PX_AW-1:0]  px_addr,
    input  logic [DW-1:0]             px_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_data,
    output logic [nn_pkg::IDX_W-1:0]  out_idx
);

    import nn_pkg::*;

    localparam logic [PX_AW-1:0] I_LAST = PX_AW'(N_IN - 1);
    localparam logic [IDX_W-1:0] N_LAST = IDX_W'(N_OUT - 1);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(Q_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(Q_MIN);

    state_e             state_q;
    state_e             state_d;
    logic [PX_AW-1:0]   i_q;
    logic [PX_AW-1:0]   i_d;
    logic [IDX_W-1:0]   n_q;
    logic [IDX_W-1:0]   n_d;
    logic [DW-1:0]      od_q;
    logic [DW-1:0]      od_d;
    logic [IDX_W-1:0]   oi_q;
    logic [IDX_W-1:0]   oi_d;

    logic               mac_clr;
    logic               mac_empty;
    logic [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0] sh;
    logic [DW-1:0]      res;

    mac_unit #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (mac_clr),
        .valid_i (w_en),
        .a_i     (w_data),
        .b_i     (px_data),
        .empty_o (mac_empty),
        .acc_o   (acc)
    );

    // Scale, saturate, then optionally rectify
    always_comb begin
        sh = $signed(acc) >>> FRAC;
        if (sh > SAT_HI) begin
            res = SAT_HI[DW-1:0];
        end else if (sh < SAT_LO) begin
            res = SAT_LO[DW-1:0];
        end else begin
            res = sh[DW-1:0];
        end
        if (RELU != 0 && sh[ACC_W-1]) begin
            res = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        n_d     = n_q;
        od_d    = od_q;
        oi_d    = oi_q;
        mac_clr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = '0;
                    i_d     = '0;
                    mac_clr = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_q == I_LAST) begin
                    i_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + PX_AW'(1);
                end
            end
            S_DRAIN: begin
                if (mac_empty) begin
                    od_d    = res;
                    oi_d    = n_q;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (n_q == N_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + IDX_W'(1);
                        i_d     = '0;
                        mac_clr = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            n_q     <= '0;
            od_q    <= '0;
            oi_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            n_q     <= n_d;
            od_q    <= od_d;
            oi_q    <= oi_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign w_en      = (state_q == S_ISSUE);
    assign out_valid = (state_q == S_OUT);
    assign px_addr   = i_q;
    assign out_data  = od_q;
    assign out_idx   = oi_q;

endmodule
